mfe_led7seg_74hc595_scanner: RTL and testbench
==============================================

// Module: mfe_led7seg_74hc595_scanner
// PURPOSE
//  Refresh scheduler for the 8-digit 74HC595 7-seg module. Holds an 8-entry digit
//  frame buffer (hex nibble, decimal point, blank), decodes each entry to a segment
//  byte and presents {seg, digit_onehot} words to the 74HC595 controller over vld/rdy.
//  Digits are scanned 0..N-1 with a programmable dwell. Shadow/active double buffer
//  gives tear-free updates.
// PARAMETERS
//  NUM_DIGITS      8     digits scanned, 1..8; idx wraps NUM_DIGITS-1 -> 0
//  DWELL_CYCLES    1000  clk cycles spent in DWELL after each accepted word, >=1
//  SEG_ACTIVE_LOW  1     1: segment byte active-low (blank = 8'hFF); 0: byte inverted
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  wr_en       in   1   write one shadow entry this cycle
//  wr_addr     in   3   digit index; writes with wr_addr >= NUM_DIGITS are ignored
//  wr_data     in   6   [3:0] hex value, [4] dp on, [5] blank digit
//  commit      in   1   pulse: copy shadow -> active at next frame start
//  pending     out  1   commit requested, copy not yet done
//  frame_done  out  1   1-cycle pulse when the last digit's dwell ends
//  dat         out  16  [15:8] segment byte, [7:0] one-hot digit select (1<<idx)
//  vld         out  1   dat valid to controller
//  rdy         in   1   controller ready; transfer when vld && rdy
// BEHAVIOUR
//  Reset: all shadow/active entries = blank; idx=0; state=LOAD; vld=0; dat=16'h0000;
//   pending=0; frame_done=0. rst has priority over every other input.
//  FSM:
//   LOAD : if idx==0 && pending: active<=shadow, pending<=0. Register dat from
//          active[idx] (post-copy contents). -> SEND next cycle.
//   SEND : vld=1, dat held stable. On vld&&rdy: vld<=0, cnt<=0 -> DWELL.
//          rdy low: remain in SEND indefinitely.
//   DWELL: cnt++; at cnt==DWELL_CYCLES-1: idx<=(idx==NUM_DIGITS-1)?0:idx+1 -> LOAD.
//          frame_done pulses on the same cycle if the wrap occurs.
//  Throughput with rdy held high: one transfer per DWELL_CYCLES+2 cycles.
//  Decode (active-low, bit7 = dp): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8,
//   8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E. dp=1 clears bit7.
//   blank=1 -> 8'hFF regardless of hex/dp. SEG_ACTIVE_LOW=0 -> ~byte.
//  Shadow write: entry updated on the edge where wr_en=1; never visible until commit.
//  commit sets pending; commit while pending: no extra effect.
//  wr_en and commit in same cycle: the write is included in that commit.
//  Writes after commit, before the copy, are also included (copy happens at LOAD).
//  cnt width = $clog2(DWELL_CYCLES+1).
//  Reset mid-operation (any state, incl. SEND with rdy low): vld=0 on the next cycle.
//   Frame restarts at digit 0 with all digits blank.
// TESTING
//  1 Reset, no writes, rdy=1: transfers FF01,FF02,..,FF80, then FF01.
//    frame_done 1 cycle after the 8th dwell.
//  2 wr addr3 data 6'h05, commit mid-frame: digit3 stays FF08 this frame, pending=1.
//    Next frame digit3 = 9208; pending=0.
//  3 wr addr0 6'h18 and commit in same cycle: next frame digit0 = 0001 (8 with dp).
//    wr 6'h28 to addr0 + commit -> FF01 (blank wins).
//  4 Hold rdy=0 for 50 cycles in SEND: vld stays 1, dat constant, idx unchanged.
//    rdy=1 -> one transfer, then vld=0.
//  5 DWELL_CYCLES=4, rdy tied 1: consecutive vld&&rdy edges exactly 6 cycles apart.
//  6 Load digits 0-7 with 0..7 and commit, then assert rst during DWELL:
//    vld=0 next cycle; first transfer after release = FF01.

Source files
------------

// File: rtl/mfe_led7seg_74hc595_scanner.sv
// mfe_led7seg_74hc595_scanner
// Refresh scheduler for an 8-digit 74HC595 seven-segment module. Keeps a
// shadow/active pair of digit frame buffers. Each active entry is decoded to a
// segment byte and offered as {seg, digit_onehot} to the shift-register
// controller over a vld/rdy handshake. After every accepted word the block
// waits a programmable dwell time before it loads the next digit.
// A commit copies shadow to active only at the start of a frame, so a
// displayed frame never mixes old and new contents.

module mfe_led7seg_74hc595_scanner #(
   parameter int NUM_DIGITS     = 8,
   parameter int DWELL_CYCLES   = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [5:0]  wr_data,
   input  logic        commit,
   output logic        pending,
   output logic        frame_done,
   output logic [15:0] dat,
   output logic        vld,
   input  logic        rdy
);

   localparam int               CNT_W       = $clog2(DWELL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [2:0]       IDX_LAST    = 3'(NUM_DIGITS - 1);
   localparam logic [3:0]       NUM_D4      = 4'(NUM_DIGITS);
   localparam logic [5:0]       ENTRY_BLANK = 6'h20;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_SEND  = 2'd1,
      ST_DWELL = 2'd2
   } state_t;

   // Entry layout: [3:0] hex value, [4] decimal point on, [5] blank digit.
   // The table is active-low with bit 7 as the decimal point.
   function automatic logic [7:0] seg_decode(input logic [5:0] entry);
      logic [7:0] seg;
      case (entry[3:0])
         4'h0:    seg = 8'hC0;
         4'h1:    seg = 8'hF9;
         4'h2:    seg = 8'hA4;
         4'h3:    seg = 8'hB0;
         4'h4:    seg = 8'h99;
         4'h5:    seg = 8'h92;
         4'h6:    seg = 8'h82;
         4'h7:    seg = 8'hF8;
         4'h8:    seg = 8'h80;
         4'h9:    seg = 8'h90;
         4'hA:    seg = 8'h88;
         4'hB:    seg = 8'h83;
         4'hC:    seg = 8'hC6;
         4'hD:    seg = 8'hA1;
         4'hE:    seg = 8'h86;
         4'hF:    seg = 8'h8E;
         default: seg = 8'hFF;
      endcase
      if (entry[4]) begin
         seg = seg & 8'h7F;
      end else begin
         seg = seg;
      end
      if (entry[5]) begin
         seg = 8'hFF;
      end else begin
         seg = seg;
      end
      if (SEG_ACTIVE_LOW) begin
         return seg;
      end else begin
         return ~seg;
      end
   endfunction

   logic [5:0]       shadow_r [8];
   logic [5:0]       active_r [8];
   state_t           state_r, state_s;
   logic [2:0]       idx_r, idx_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic             vld_r, vld_s;
   logic [15:0]      dat_r, dat_s;
   logic             pending_r, pending_s;
   logic             frame_done_r, frame_done_s;
   logic             copy_s;
   logic [5:0]       entry_s;
   logic             wr_ok_s;

   assign wr_ok_s    = wr_en && ({1'b0, wr_addr} < NUM_D4);
   assign dat        = dat_r;
   assign vld        = vld_r;
   assign pending    = pending_r;
   assign frame_done = frame_done_r;

   // Next-state and next-output logic for the LOAD/SEND/DWELL scan sequence.
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      cnt_s        = cnt_r;
      vld_s        = vld_r;
      dat_s        = dat_r;
      frame_done_s = 1'b0;
      copy_s       = 1'b0;
      entry_s      = active_r[idx_r];
      case (state_r)
         ST_LOAD: begin
            // The frame starts at digit 0. The copy happens on this edge, so
            // digit 0 is decoded straight from the shadow buffer.
            copy_s = (idx_r == 3'd0) && pending_r;
            if (copy_s) begin
               entry_s = shadow_r[idx_r];
            end else begin
               entry_s = active_r[idx_r];
            end
            dat_s   = {seg_decode(entry_s), 8'(8'd1 << idx_r)};
            vld_s   = 1'b1;
            state_s = ST_SEND;
         end
         ST_SEND: begin
            if (rdy) begin
               vld_s   = 1'b0;
               cnt_s   = {CNT_W{1'b0}};
               state_s = ST_DWELL;
            end else begin
               vld_s   = 1'b1;
            end
         end
         ST_DWELL: begin
            if (cnt_r == CNT_LAST) begin
               idx_s        = (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
               frame_done_s = (idx_r == IDX_LAST);
               state_s      = ST_LOAD;
            end else begin
               cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            vld_s   = 1'b0;
            state_s = ST_LOAD;
         end
      endcase
      // A fresh commit on the copy edge re-arms the request for the next frame.
      if (commit) begin
         pending_s = 1'b1;
      end else if (copy_s) begin
         pending_s = 1'b0;
      end else begin
         pending_s = pending_r;
      end
   end

   // Scan state, counters and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_LOAD;
         idx_r        <= 3'd0;
         cnt_r        <= {CNT_W{1'b0}};
         vld_r        <= 1'b0;
         dat_r        <= 16'h0000;
         pending_r    <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         idx_r        <= idx_s;
         cnt_r        <= cnt_s;
         vld_r        <= vld_s;
         dat_r        <= dat_s;
         pending_r    <= pending_s;
         frame_done_r <= frame_done_s;
      end
   end

   // Shadow buffer: host writes land here and stay invisible until a commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            shadow_r[i] <= ENTRY_BLANK;
         end
      end else if (wr_ok_s) begin
         shadow_r[wr_addr] <= wr_data;
      end
   end

   // Active buffer: the whole frame is replaced at once when a frame starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            active_r[i] <= ENTRY_BLANK;
         end
      end else if (copy_s) begin
         for (int i = 0; i < 8; i++) begin
            active_r[i] <= shadow_r[i];
         end
      end
   end

endmodule

// File: tb/tb_mfe_led7seg_74hc595_scanner.sv
// Self-checking bench for mfe_led7seg_74hc595_scanner.
// A frame-level reference model tracks the shadow/active buffers, the commit
// request and the display timing. The timing is one word, then a dwell of
// DWELL cycles, then one load cycle. The model predicts vld, dat, pending and
// frame_done on every cycle.

module tb_mfe_led7seg_74hc595_scanner;

   localparam int NDIG  = 8;
   localparam int DWELL = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [5:0]  wr_data = 6'd0;
   logic        commit = 1'b0;
   logic        pending;
   logic        frame_done;
   logic [15:0] dat;
   logic        vld;
   logic        rdy = 1'b1;

   mfe_led7seg_74hc595_scanner #(
      .NUM_DIGITS(NDIG), .DWELL_CYCLES(DWELL), .SEG_ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .pending(pending), .frame_done(frame_done),
      .dat(dat), .vld(vld), .rdy(rdy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [5:0]  m_shadow [NDIG];
   logic [5:0]  m_active [NDIG];
   bit          m_pending, m_vld, fd_exp, last_was_last;
   int          m_idx, load_in, cyc, fd_seen;
   logic [15:0] xq[$];
   int          xcyc[$];

   function automatic logic [15:0] m_word(input logic [5:0] e, input int i);
      logic [7:0] s;
      if (e[5]) s = 8'hFF;
      else if (e[4]) s = seg_tbl[e[3:0]] & 8'h7F;
      else s = seg_tbl[e[3:0]];
      return {s, 8'(1 << i)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NDIG; i++) begin
         m_shadow[i] = 6'h20;
         m_active[i] = 6'h20;
      end
      m_pending = 1'b0; m_vld = 1'b0; fd_exp = 1'b0; last_was_last = 1'b0;
      m_idx = 0; load_in = 1;
   endtask

   // One clock: advance the model across the edge, then compare the DUT with it.
   task automatic tick();
      bit xfer, is_load;
      xfer = (vld === 1'b1) && (rdy === 1'b1) && !rst;
      if (xfer) begin
         xq.push_back(dat);
         xcyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
         model_reset();
      end else begin
         is_load = (load_in == 1);
         if (load_in > 0) load_in--;
         if (is_load) begin
            if (m_idx == 0 && m_pending) begin
               m_active  = m_shadow;
               m_pending = 1'b0;
            end
            m_vld = 1'b1;
         end
         if (wr_en && int'(wr_addr) < NDIG) m_shadow[wr_addr] = wr_data;
         if (commit) m_pending = 1'b1;
         if (xfer) begin
            last_was_last = (m_idx == NDIG - 1);
            m_idx   = (m_idx + 1) % NDIG;
            m_vld   = 1'b0;
            load_in = DWELL + 1;
         end
         fd_exp = (load_in == 1) && last_was_last;
      end
      #1;
      if (frame_done === 1'b1) fd_seen++;
      n_checks++;
      if (vld !== m_vld) begin
         n_fail++; $display("FAIL vld cyc=%0d got %b exp %b", cyc, vld, m_vld);
      end
      n_checks++;
      if (pending !== m_pending) begin
         n_fail++; $display("FAIL pending cyc=%0d got %b exp %b", cyc, pending, m_pending);
      end
      n_checks++;
      if (frame_done !== fd_exp) begin
         n_fail++; $display("FAIL frame_done cyc=%0d got %b exp %b", cyc, frame_done, fd_exp);
      end
      if (m_vld) begin
         n_checks++;
         if (dat !== m_word(m_active[m_idx], m_idx)) begin
            n_fail++;
            $display("FAIL dat cyc=%0d got %h exp %h", cyc, dat, m_word(m_active[m_idx], m_idx));
         end
      end
   endtask

   task automatic run_xfers(input int n);
      int start, k;
      start = xq.size(); k = 0;
      while (xq.size() < start + n && k < 2000) begin
         tick(); k++;
      end
      if (xq.size() < start + n) begin
         n_checks++; n_fail++;
         $display("FAIL xfer_timeout got %0d exp %0d transfers", xq.size() - start, n);
      end
   endtask

   task automatic wait_idx(input int target);
      int k;
      k = 0;
      while (m_idx != target && k < 200) begin
         tick(); k++;
      end
      if (m_idx != target) begin
         n_checks++; n_fail++;
         $display("FAIL wait_idx got %0d exp %0d", m_idx, target);
      end
   endtask

   task automatic write_commit(input logic [2:0] a, input logic [5:0] d, input bit c);
      wr_en = 1'b1; wr_addr = a; wr_data = d; commit = c;
      tick();
      wr_en = 1'b0; commit = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rdy = 1'b1;
      tick(); tick();
      n_checks++;
      if (dat !== 16'h0000) begin
         n_fail++; $display("FAIL reset_dat got %h exp 0000", dat);
      end
      rst = 1'b0;
   endtask

   task automatic test_blank_frame();
      logic [15:0] exp_w;
      xq.delete(); fd_seen = 0;
      run_xfers(9);
      for (int i = 0; i < 9; i++) begin
         exp_w = {8'hFF, 8'(1 << (i % 8))};
         n_checks++;
         if (xq.size() <= i || xq[i] !== exp_w) begin
            n_fail++;
            $display("FAIL blank_frame[%0d] got %h exp %h", i, (xq.size() > i) ? xq[i] : 16'hxxxx, exp_w);
         end
      end
      n_checks++;
      if (fd_seen != 1) begin
         n_fail++; $display("FAIL frame_done_count got %0d exp 1", fd_seen);
      end
   endtask

   task automatic test_commit_midframe();
      wait_idx(1);
      write_commit(3'd3, 6'h05, 1'b1);
      xq.delete();
      run_xfers(3);
      n_checks++;
      if (xq.size() < 3 || xq[2] !== 16'hFF08) begin
         n_fail++; $display("FAIL midframe_old got %h exp FF08", (xq.size() > 2) ? xq[2] : 16'hxxxx);
      end
      n_checks++;
      if (pending !== 1'b1) begin
         n_fail++; $display("FAIL midframe_pending got %b exp 1", pending);
      end
      run_xfers(8);
      n_checks++;
      if (xq.size() < 11 || xq[10] !== 16'h9208) begin
         n_fail++; $display("FAIL midframe_new got %h exp 9208", (xq.size() > 10) ? xq[10] : 16'hxxxx);
      end
      n_checks++;
      if (pending !== 1'b0) begin
         n_fail++; $display("FAIL midframe_pending_clr got %b exp 0", pending);
      end
   endtask

   task automatic test_same_cycle_commit();
      wait_idx(2);
      write_commit(3'd0, 6'h18, 1'b1);
      xq.delete();
      run_xfers(7);
      n_checks++;
      if (xq.size() < 7 || xq[6] !== 16'h0001) begin
         n_fail++; $display("FAIL same_cycle_dp8 got %h exp 0001", (xq.size() > 6) ? xq[6] : 16'hxxxx);
      end
      wait_idx(2);
      write_commit(3'd0, 6'h28, 1'b1);
      xq.delete();
      run_xfers(7);
      n_checks++;
      if (xq.size() < 7 || xq[6] !== 16'hFF01) begin
         n_fail++; $display("FAIL blank_wins got %h exp FF01", (xq.size() > 6) ? xq[6] : 16'hxxxx);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] held;
      int k;
      k = 0;
      while (!m_vld && k < 50) begin
         tick(); k++;
      end
      rdy  = 1'b0;
      held = dat;
      for (int i = 0; i < 50; i++) begin
         tick();
         n_checks++;
         if (vld !== 1'b1 || dat !== held) begin
            n_fail++; $display("FAIL hold[%0d] got vld=%b dat=%h exp vld=1 dat=%h", i, vld, dat, held);
         end
      end
      rdy = 1'b1;
      xq.delete();
      tick();
      n_checks++;
      if (vld !== 1'b0 || xq.size() != 1 || xq[0] !== held) begin
         n_fail++; $display("FAIL release got vld=%b n=%0d exp vld=0 n=1 dat=%h", vld, xq.size(), held);
      end
   endtask

   task automatic test_back_to_back();
      rdy = 1'b1;
      xcyc.delete();
      run_xfers(3);
      for (int i = 1; i < 3; i++) begin
         n_checks++;
         if (xcyc.size() < 3 || xcyc[i] - xcyc[i-1] != DWELL + 2) begin
            n_fail++;
            $display("FAIL spacing[%0d] got %0d exp %0d", i,
                     (xcyc.size() > i) ? xcyc[i] - xcyc[i-1] : -1, DWELL + 2);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         rdy     = ($urandom_range(0, 3) != 0);
         wr_en   = ($urandom_range(0, 7) == 0);
         wr_addr = 3'($urandom_range(0, 7));
         wr_data = 6'($urandom);
         commit  = ($urandom_range(0, 15) == 0);
         tick();
      end
      wr_en = 1'b0; commit = 1'b0; rdy = 1'b1;
   endtask

   task automatic test_reset_mid();
      int k;
      for (int i = 0; i < 8; i++) write_commit(3'(i), 6'(i), (i == 7));
      run_xfers(16);
      k = 0;
      while (!(!m_vld && load_in > 2) && k < 50) begin
         tick(); k++;
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if (vld !== 1'b0) begin
         n_fail++; $display("FAIL rst_dwell_vld got %b exp 0", vld);
      end
      rst = 1'b0;
      xq.delete();
      run_xfers(1);
      n_checks++;
      if (xq.size() < 1 || xq[0] !== 16'hFF01) begin
         n_fail++; $display("FAIL rst_first_word got %h exp FF01", (xq.size() > 0) ? xq[0] : 16'hxxxx);
      end
      // reset while stalled in SEND
      rdy = 1'b0;
      k = 0;
      while (!m_vld && k < 50) begin
         tick(); k++;
      end
      tick();
      rst = 1'b1;
      tick();
      n_checks++;
      if (vld !== 1'b0) begin
         n_fail++; $display("FAIL rst_send_vld got %b exp 0", vld);
      end
      rst = 1'b0; rdy = 1'b1;
      xq.delete();
      run_xfers(1);
      n_checks++;
      if (xq.size() < 1 || xq[0] !== 16'hFF01) begin
         n_fail++; $display("FAIL rst_send_first got %h exp FF01", (xq.size() > 0) ? xq[0] : 16'hxxxx);
      end
   endtask

   initial begin
      cyc = 0; fd_seen = 0;
      model_reset();
      test_reset();
      test_blank_frame();
      test_commit_midframe();
      test_same_cycle_commit();
      test_backpressure();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
